apb_arb_mux: RTL and testbench

APB_ARB_MUX -- requirements
Module: apb_arb_mux

---
 rtl/apb_arb_mux_pkg.sv | 20 ++
 rtl/apb_rr_arbiter.sv | 51 +++++
 rtl/apb_arb_mux.sv | 180 ++++++++++++++++++
 tb/tb_apb_arb_mux.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_mux_pkg.sv
// ---------------------------------------------------------------------------
// apb_arb_mux_pkg
// Shared types and constants for the APB arbiter/multiplexer.
//   state_t   : transfer sequencer states (IDLE, SETUP, ACCESS, ABORT)
//   ARB_RR    : round-robin arbitration mode selector value
//   ARB_FIXED : fixed-priority arbitration mode selector value (index 0 wins)
// ---------------------------------------------------------------------------
package apb_arb_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ABORT  = 2'd3
    } state_t;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

endpackage

// File: rtl/apb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// apb_rr_arbiter
// Combinational requester selection. In round-robin mode the search starts at
// i_ptr and wraps; in fixed mode the search always starts at index 0, so the
// lowest requesting index wins.
//   i_req       : request vector, one bit per master
//   i_ptr       : round-robin search start index
//   i_mode      : 0 = round-robin, 1 = fixed priority
//   o_grant_oh  : one-hot grant (all zero when nothing requests)
//   o_grant_idx : binary index of the winner (0 when nothing requests)
//   o_valid     : at least one request present
// ---------------------------------------------------------------------------
module apb_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    localparam int IDX_W      = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_ptr,
    input  logic                   i_mode,
    output logic [NUM_MASTERS-1:0] o_grant_oh,
    output logic [IDX_W-1:0]       o_grant_idx,
    output logic                   o_valid
);

    // One extra bit so ptr + offset never overflows before the wrap check.
    localparam logic [IDX_W:0] NM = (IDX_W + 1)'(NUM_MASTERS);

    logic [IDX_W-1:0] w_start;
    logic [IDX_W:0]   w_idx;

    assign w_start = i_mode ? '0 : i_ptr;

    always_comb begin
        o_valid     = 1'b0;
        o_grant_idx = '0;
        o_grant_oh  = '0;
        w_idx       = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_idx = {1'b0, w_start} + (IDX_W + 1)'(i);
            if (w_idx >= NM) begin
                w_idx = w_idx - NM;
            end
            if (!o_valid && i_req[w_idx[IDX_W-1:0]]) begin
                o_valid     = 1'b1;
                o_grant_idx = w_idx[IDX_W-1:0];
            end
        end
        o_grant_oh[o_grant_idx] = o_valid;
    end

endmodule

// File: rtl/apb_arb_mux.sv
// ---------------------------------------------------------------------------
// apb_arb_mux
// Arbitrates NUM_MASTERS APB requesters onto one APB slave port. One transfer
// at a time runs IDLE -> SETUP -> ACCESS -> IDLE; a watchdog converts a stuck
// ACCESS phase into a one-cycle ABORT that returns PSLVERR to the owner.
//   PCLK, PRESETn                  : clock, async active-low reset
//   PSEL_s/PWRITE_s/PENABLE_s      : per-master controls (PENABLE_s not used;
//                                    the mux generates its own phases)
//   PADDR_s/PWDATA_s/PSTRB_s/PPROT_s : per-master payload
//   PRDATA_s/PREADY_s/PSLVERR_s    : per-master response (only owner non-zero)
//   PSEL_m/PENABLE_m/PWRITE_m/PADDR_m/PWDATA_m/PSTRB_m/PPROT_m : slave side
//   PRDATA_m/PREADY_m/PSLVERR_m    : slave response
//   grant_id                       : owning master index (held until next grant)
//   busy                           : transfer in progress (SETUP/ACCESS/ABORT)
//   timeout_pulse                  : high for the single ABORT cycle
// ---------------------------------------------------------------------------
module apb_arb_mux
    import apb_arb_mux_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ARB_MODE    = ARB_RR,
    parameter int TIMEOUT     = 256,
    localparam int STRB_W     = DATA_W / 8,
    localparam int IDX_W      = $clog2(NUM_MASTERS)
) (
    input  logic                               PCLK,
    input  logic                               PRESETn,
    input  logic [NUM_MASTERS-1:0]             PSEL_s,
    input  logic [NUM_MASTERS-1:0]             PWRITE_s,
    input  logic [NUM_MASTERS-1:0]             PENABLE_s,
    input  logic [NUM_MASTERS-1:0][ADDR_W-1:0] PADDR_s,
    input  logic [NUM_MASTERS-1:0][DATA_W-1:0] PWDATA_s,
    input  logic [NUM_MASTERS-1:0][STRB_W-1:0] PSTRB_s,
    input  logic [NUM_MASTERS-1:0][2:0]        PPROT_s,
    output logic [NUM_MASTERS-1:0][DATA_W-1:0] PRDATA_s,
    output logic [NUM_MASTERS-1:0]             PREADY_s,
    output logic [NUM_MASTERS-1:0]             PSLVERR_s,
    output logic                               PSEL_m,
    output logic                               PENABLE_m,
    output logic                               PWRITE_m,
    output logic [ADDR_W-1:0]                  PADDR_m,
    output logic [DATA_W-1:0]                  PWDATA_m,
    output logic [STRB_W-1:0]                  PSTRB_m,
    output logic [2:0]                         PPROT_m,
    input  logic [DATA_W-1:0]                  PRDATA_m,
    input  logic                               PREADY_m,
    input  logic                               PSLVERR_m,
    output logic [IDX_W-1:0]                   grant_id,
    output logic                               busy,
    output logic                               timeout_pulse
);

    // Counter must be able to hold TIMEOUT itself; width 1 when disabled.
    localparam int               CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LIMIT  = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_MASTERS - 1);
    localparam logic             USE_FIXED = (ARB_MODE == ARB_FIXED);

    state_t                 r_state;
    logic [IDX_W-1:0]       r_grant;
    logic [NUM_MASTERS-1:0] r_grant_oh;
    logic [IDX_W-1:0]       r_ptr;
    logic [CNT_W-1:0]       r_wdog;

    logic [NUM_MASTERS-1:0] w_arb_oh;
    logic [IDX_W-1:0]       w_arb_idx;
    logic                   w_arb_vld;
    logic [CNT_W-1:0]       w_wdog_inc;
    logic                   w_wdog_expire;
    logic [IDX_W-1:0]       w_ptr_next;
    logic                   w_on_bus;
    logic                   w_access;
    logic                   w_abort;

    // Masters' own PENABLE is irrelevant: the mux sequences the slave phases.
    logic                   w_unused_penable;
    assign w_unused_penable = ^PENABLE_s;

    apb_rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_arb (
        .i_req       (PSEL_s),
        .i_ptr       (r_ptr),
        .i_mode      (USE_FIXED),
        .o_grant_oh  (w_arb_oh),
        .o_grant_idx (w_arb_idx),
        .o_valid     (w_arb_vld)
    );

    assign w_wdog_inc    = r_wdog + CNT_W'(1);
    assign w_wdog_expire = (TIMEOUT != 0) && (w_wdog_inc == TO_LIMIT);
    assign w_ptr_next    = (r_grant == LAST_IDX) ? '0 : r_grant + IDX_W'(1);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_grant_oh <= '0;
            r_ptr      <= '0;
            r_wdog     <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_arb_vld) begin
                        r_grant    <= w_arb_idx;
                        r_grant_oh <= w_arb_oh;
                        r_state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_wdog  <= '0;
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // A slave answering on the last allowed cycle still wins.
                    if (PREADY_m) begin
                        r_state <= ST_IDLE;
                        if (!USE_FIXED) r_ptr <= w_ptr_next;
                    end else if (w_wdog_expire) begin
                        r_state <= ST_ABORT;
                    end else begin
                        r_wdog <= w_wdog_inc;
                    end
                end
                ST_ABORT: begin
                    r_state <= ST_IDLE;
                    if (!USE_FIXED) r_ptr <= w_ptr_next;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_on_bus      = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign w_access      = (r_state == ST_ACCESS);
    assign w_abort       = (r_state == ST_ABORT);
    assign grant_id      = r_grant;
    assign busy          = (r_state != ST_IDLE);
    assign timeout_pulse = w_abort;

    // Slave-side payload follows the owner only while the bus is driven.
    always_comb begin
        PSEL_m    = 1'b0;
        PENABLE_m = 1'b0;
        PWRITE_m  = 1'b0;
        PADDR_m   = '0;
        PWDATA_m  = '0;
        PSTRB_m   = '0;
        PPROT_m   = '0;
        if (w_on_bus) begin
            PSEL_m    = 1'b1;
            PENABLE_m = w_access;
            PWRITE_m  = PWRITE_s[r_grant];
            PADDR_m   = PADDR_s[r_grant];
            PWDATA_m  = PWDATA_s[r_grant];
            PSTRB_m   = PSTRB_s[r_grant];
            PPROT_m   = PPROT_s[r_grant];
        end
    end

    // Response goes only to the owner; an abort forces an error completion.
    always_comb begin
        PRDATA_s  = '0;
        PREADY_s  = '0;
        PSLVERR_s = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_access && r_grant_oh[i]) begin
                PRDATA_s[i]  = PRDATA_m;
                PREADY_s[i]  = PREADY_m;
                PSLVERR_s[i] = PSLVERR_m;
            end else if (w_abort && r_grant_oh[i]) begin
                PREADY_s[i]  = 1'b1;
                PSLVERR_s[i] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_arb_mux.sv
module tb_apb_arb_mux;

    localparam int NM  = 4;
    localparam int TO  = 8;
    localparam int PH_IDLE   = 0;
    localparam int PH_SETUP  = 1;
    localparam int PH_ACCESS = 2;
    localparam int PH_ABORT  = 3;

    logic             clk = 1'b0;
    logic             prst_n;
    logic [NM-1:0]    psel_s, pwrite_s, penable_s;
    logic [NM-1:0][31:0] paddr_s, pwdata_s;
    logic [NM-1:0][3:0]  pstrb_s;
    logic [NM-1:0][2:0]  pprot_s;
    logic [31:0]      prdata_m;
    logic             pready_m, pslverr_m;

    // index 0: round-robin instance, index 1: fixed-priority instance
    logic [NM-1:0][31:0] prdata_s [2];
    logic [NM-1:0]    pready_s [2];
    logic [NM-1:0]    pslverr_s [2];
    logic             psel_m [2];
    logic             penable_m [2];
    logic             pwrite_m [2];
    logic [31:0]      paddr_m [2];
    logic [31:0]      pwdata_m [2];
    logic [3:0]       pstrb_m [2];
    logic [2:0]       pprot_m [2];
    logic [1:0]       grant_id [2];
    logic             busy [2];
    logic             tpulse [2];

    int nchk = 0;
    int nerr = 0;
    int ptr_m = 0;

    always #5 clk = ~clk;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        apb_arb_mux #(
            .NUM_MASTERS (NM),
            .ADDR_W      (32),
            .DATA_W      (32),
            .ARB_MODE    (d),
            .TIMEOUT     (TO)
        ) u_dut (
            .PCLK          (clk),
            .PRESETn       (prst_n),
            .PSEL_s        (psel_s),
            .PWRITE_s      (pwrite_s),
            .PENABLE_s     (penable_s),
            .PADDR_s       (paddr_s),
            .PWDATA_s      (pwdata_s),
            .PSTRB_s       (pstrb_s),
            .PPROT_s       (pprot_s),
            .PRDATA_s      (prdata_s[d]),
            .PREADY_s      (pready_s[d]),
            .PSLVERR_s     (pslverr_s[d]),
            .PSEL_m        (psel_m[d]),
            .PENABLE_m     (penable_m[d]),
            .PWRITE_m      (pwrite_m[d]),
            .PADDR_m       (paddr_m[d]),
            .PWDATA_m      (pwdata_m[d]),
            .PSTRB_m       (pstrb_m[d]),
            .PPROT_m       (pprot_m[d]),
            .PRDATA_m      (prdata_m),
            .PREADY_m      (pready_m),
            .PSLVERR_m     (pslverr_m),
            .grant_id      (grant_id[d]),
            .busy          (busy[d]),
            .timeout_pulse (tpulse[d])
        );
    end

    // ---------------- reference model (transaction level) ----------------
    function automatic int rr_pick(input logic [NM-1:0] req, input int p);
        for (int i = 0; i < NM; i++) begin
            if (req[(p + i) % NM]) return (p + i) % NM;
        end
        return 0;
    endfunction

    function automatic int fx_pick(input logic [NM-1:0] req);
        for (int i = 0; i < NM; i++) begin
            if (req[i]) return i;
        end
        return 0;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cycle(input int ph, input int g_rr, input int g_fx);
        string            pn;
        string            tg;
        int               g;
        logic             on;
        logic [NM-1:0][31:0] e_rd;
        logic [NM-1:0]    e_rdy, e_err;
        pn = (ph == PH_IDLE) ? "idle" : (ph == PH_SETUP) ? "setup" :
             (ph == PH_ACCESS) ? "access" : "abort";
        for (int d = 0; d < 2; d++) begin
            g     = (d == 0) ? g_rr : g_fx;
            tg    = $sformatf("%s/%s", (d == 0) ? "rr" : "fx", pn);
            on    = (ph == PH_SETUP) || (ph == PH_ACCESS);
            e_rd  = '0;
            e_rdy = '0;
            e_err = '0;
            if (ph == PH_ACCESS) begin
                e_rd[g]  = prdata_m;
                e_rdy[g] = pready_m;
                e_err[g] = pslverr_m;
            end else if (ph == PH_ABORT) begin
                e_rdy[g] = 1'b1;
                e_err[g] = 1'b1;
            end
            chk({tg, " PSEL_m"},    psel_m[d], on);
            chk({tg, " PENABLE_m"}, penable_m[d], ph == PH_ACCESS);
            chk({tg, " busy"},      busy[d], ph != PH_IDLE);
            chk({tg, " tpulse"},    tpulse[d], ph == PH_ABORT);
            chk({tg, " grant_id"},  grant_id[d], g);
            chk({tg, " PADDR_m"},   paddr_m[d],  on ? paddr_s[g]  : 32'd0);
            chk({tg, " PWDATA_m"},  pwdata_m[d], on ? pwdata_s[g] : 32'd0);
            chk({tg, " PSTRB_m"},   pstrb_m[d],  on ? pstrb_s[g]  : 4'd0);
            chk({tg, " PPROT_m"},   pprot_m[d],  on ? pprot_s[g]  : 3'd0);
            chk({tg, " PWRITE_m"},  pwrite_m[d], on ? pwrite_s[g] : 1'b0);
            chk({tg, " PRDATA_s"},  prdata_s[d], e_rd);
            chk({tg, " PREADY_s"},  pready_s[d], e_rdy);
            chk({tg, " PSLVERR_s"}, pslverr_s[d], e_err);
        end
    endtask

    // One full transfer: w = ACCESS cycles before PREADY_m (>= TO means abort).
    task automatic run_txn(input logic [NM-1:0] req, input int w, input bit drop,
                           input logic [31:0] rd, input logic err,
                           input int e_rr, input int e_fx);
        bit done;
        psel_s    = req;
        pwrite_s  = NM'($urandom);
        paddr_s   = {$urandom, $urandom, $urandom, $urandom};
        pwdata_s  = {$urandom, $urandom, $urandom, $urandom};
        pstrb_s   = 16'($urandom);
        pprot_s   = 12'($urandom);
        pready_m  = 1'b0;
        pslverr_m = 1'b0;
        prdata_m  = $urandom;
        step();
        check_cycle(PH_SETUP, e_rr, e_fx);
        if (drop) psel_s = '0;
        step();
        done = 1'b0;
        for (int k = 0; k < TO && !done; k++) begin
            pready_m  = (k == w);
            pslverr_m = (k == w) ? err : 1'b0;
            prdata_m  = (k == w) ? rd : $urandom;
            #1;
            check_cycle(PH_ACCESS, e_rr, e_fx);
            done = (k == w);
            step();
            pready_m  = 1'b0;
            pslverr_m = 1'b0;
        end
        if (!done) begin
            check_cycle(PH_ABORT, e_rr, e_fx);
            step();
        end
        check_cycle(PH_IDLE, e_rr, e_fx);
        ptr_m = (e_rr + 1) % NM;
    endtask

    typedef struct {
        logic [NM-1:0] req;
        int            w;
        bit            drop;
        logic [31:0]   rd;
        int            e_rr;
        int            e_fx;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, nerr=%0d", nerr);
        $fatal(1, "timeout");
    end

    initial begin
        int               r_rr, r_fx;
        logic [NM-1:0]    rq;

        vecs[0]  = '{4'hF,    0, 1'b0, 32'h1111_0000, 0, 0};
        vecs[1]  = '{4'hF,    0, 1'b0, 32'h1111_0001, 1, 0};
        vecs[2]  = '{4'hF,    0, 1'b0, 32'h1111_0002, 2, 0};
        vecs[3]  = '{4'hF,    0, 1'b0, 32'h1111_0003, 3, 0};
        vecs[4]  = '{4'hF,    0, 1'b0, 32'h1111_0004, 0, 0};
        vecs[5]  = '{4'b1010, 0, 1'b0, 32'h2222_0000, 1, 1};
        vecs[6]  = '{4'b1010, 3, 1'b1, 32'hDEAD_BEEF, 3, 1};
        vecs[7]  = '{4'b1010, 99, 1'b0, 32'h3333_0000, 1, 1};
        vecs[8]  = '{4'b1010, 7, 1'b1, 32'h4444_0000, 3, 1};
        vecs[9]  = '{4'b0100, 0, 1'b1, 32'h5555_0000, 2, 2};
        vecs[10] = '{4'b0001, 2, 1'b0, 32'h6666_0000, 0, 0};
        vecs[11] = '{4'b1000, 0, 1'b1, 32'h7777_0000, 3, 3};

        prst_n    = 1'b0;
        psel_s    = '0;
        pwrite_s  = '0;
        penable_s = '0;
        paddr_s   = '0;
        pwdata_s  = '0;
        pstrb_s   = '0;
        pprot_s   = '0;
        prdata_m  = '0;
        pready_m  = 1'b0;
        pslverr_m = 1'b0;
        step();
        step();
        check_cycle(PH_IDLE, 0, 0);
        #3 prst_n = 1'b1;
        step();
        check_cycle(PH_IDLE, 0, 0);

        // directed table
        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].req, vecs[i].w, vecs[i].drop, vecs[i].rd, 1'b0,
                    vecs[i].e_rr, vecs[i].e_fx);
        end

        // randomized transfers against the model
        for (int i = 0; i < 40; i++) begin
            rq   = NM'($urandom_range(1, 15));
            r_rr = rr_pick(rq, ptr_m);
            r_fx = fx_pick(rq);
            run_txn(rq, $urandom_range(0, 10), 1'($urandom), $urandom,
                    ($urandom_range(0, 3) == 0), r_rr, r_fx);
        end

        // reset in the middle of ACCESS; ptr must restart at 0
        run_txn(4'b0001, 0, 1'b1, 32'h0, 1'b0, 0, 0);
        r_rr = rr_pick(4'hF, ptr_m);
        psel_s   = 4'hF;
        pready_m = 1'b0;
        step();
        check_cycle(PH_SETUP, r_rr, 0);
        step();
        #1;
        check_cycle(PH_ACCESS, r_rr, 0);
        prst_n = 1'b0;
        #1;
        check_cycle(PH_IDLE, 0, 0);
        step();
        check_cycle(PH_IDLE, 0, 0);
        #2 prst_n = 1'b1;
        ptr_m = 0;
        run_txn(4'hF, 1, 1'b0, 32'hCAFE_F00D, 1'b0, rr_pick(4'hF, ptr_m), 0);
        run_txn(4'hF, 0, 1'b1, 32'h0BAD_F00D, 1'b1, rr_pick(4'hF, ptr_m), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
